// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if: program-load port, start/status and the DIN/Run/Done link to the core.
`timescale 1ns/1ps
interface prog_sequencer_if #(
    parameter int W  = 9,
    parameter int AW = 5
);
    logic          Start;
    logic [AW-1:0] LastAddr;
    logic          LdEn;
    logic [AW-1:0] LdAddr;
    logic [W-1:0]  LdData;
    logic          Done;
    logic [W-1:0]  DIN;
    logic          Run;
    logic [AW-1:0] PC;
    logic          Busy;
    logic          Halted;
    logic          Err;

    modport master (
        output Start, LastAddr, LdEn, LdAddr, LdData, Done,
        input  DIN, Run, PC, Busy, Halted, Err
    );

    modport slave (
        input  Start, LastAddr, LdEn, LdAddr, LdData, Done,
        output DIN, Run, PC, Busy, Halted, Err
    );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: program RAM that feeds the core one instruction per Run pulse, adding the
// mvi immediate, waiting for Done, stopping at LastAddr or on a Done timeout.
`timescale 1ns/1ps
module prog_sequencer #(
    parameter int W       = 9,
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input logic             Clock,
    input logic             Resetn,
    prog_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HALT, ERR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, last_q, last_d, consumed;
    logic [TW-1:0] timer_q, timer_d;
    logic          is_mvi_q, is_mvi_d, idle_like, we;
    logic [W-1:0]  mem [2**AW];
    logic [W-1:0]  rd;

    assign rd        = mem[pc_q];
    assign idle_like = (state_q == IDLE) || (state_q == HALT) || (state_q == ERR);
    assign we        = idle_like && bus.LdEn && !bus.Start;
    // PC already points past the opcode in WAIT; an mvi also consumes the word at PC.
    assign consumed  = is_mvi_q ? pc_q : pc_q - AW'(1);

    always_ff @(posedge Clock) begin
        if (we) mem[bus.LdAddr] <= bus.LdData;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            last_q   <= '0;
            timer_q  <= '0;
            is_mvi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            is_mvi_q <= is_mvi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        last_d   = last_q;
        timer_d  = timer_q;
        is_mvi_d = is_mvi_q;
        case (state_q)
            ISSUE: begin
                is_mvi_d = rd[W-1:W-3] == 3'b001;
                pc_d     = pc_q + AW'(1);
                state_d  = WAIT;
            end
            WAIT: begin
                if (bus.Done) begin
                    pc_d    = is_mvi_q ? pc_q + AW'(1) : pc_q;
                    timer_d = '0;
                    state_d = (consumed == last_q) ? HALT : ISSUE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                if (bus.Start) begin
                    state_d = ISSUE;
                    pc_d    = '0;
                    last_d  = bus.LastAddr;
                    timer_d = '0;
                end
            end
        endcase
    end

    assign bus.Run    = state_q == ISSUE;
    assign bus.DIN    = (state_q == ISSUE || state_q == WAIT) ? rd : '0;
    assign bus.PC     = pc_q;
    assign bus.Busy   = state_q == ISSUE || state_q == WAIT;
    assign bus.Halted = state_q == HALT;
    assign bus.Err    = state_q == ERR;
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: walks each loaded program at instruction level to predict every Run word,
// mvi immediate, busy span and final PC/Halted/Err, and checks the DUT cycle by cycle.
`timescale 1ns/1ps
module tb_prog_sequencer;
    localparam int TO = 15;

    typedef struct {
        int addr;
        int word;
        bit mvi;
        int imm;
    } iss_t;

    logic Clock = 1'b0;
    logic Resetn = 1'b1;

    prog_sequencer_if #(.W(9), .AW(5)) bus ();
    prog_sequencer_if #(.W(9), .AW(2)) sbus ();

    prog_sequencer #(.W(9), .AW(5), .TIMEOUT(TO)) dut (.Clock(Clock), .Resetn(Resetn), .bus(bus));
    prog_sequencer #(.W(9), .AW(2), .TIMEOUT(TO)) dut_s (.Clock(Clock), .Resetn(Resetn), .bus(sbus));

    always #5 Clock = ~Clock;

    int   checks = 0, errors = 0;
    int   cyc = 0, last_run = -10, busy_cnt = 0;
    int   core_dly = 1, pend = 0, imm_val = 0;
    bit   imm_pend = 0, err_prev = 0, core_r = 0;
    int   exp_pc, exp_halt, exp_busy;
    logic [8:0] pm [32];
    iss_t exp_q[$];
    int   run_din[$], imm_log[$], pcs[$];

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    // Instruction-level walk: issue word at a; mvi consumes a+1; stop when consumed == last.
    function automatic void walk(input int last, input int dly);
        int a = 0;
        int cons;
        exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            iss_t e;
            e.addr = a;
            e.word = int'(pm[a]);
            e.mvi  = pm[a][8:6] == 3'b001;
            e.imm  = int'(pm[(a + 1) % 32]);
            exp_q.push_back(e);
            if (dly == 0 || dly > TO) begin
                exp_halt = 0;
                exp_pc   = (a + 1) % 32;
                exp_busy = (exp_q.size() - 1) * (1 + dly) + 1 + TO;
                return;
            end
            cons = e.mvi ? (a + 1) % 32 : a;
            a    = e.mvi ? (a + 2) % 32 : (a + 1) % 32;
            if (cons == last) begin
                exp_halt = 1;
                exp_pc   = a;
                exp_busy = exp_q.size() * (1 + dly);
                return;
            end
        end
    endfunction

    // Core stand-in: Done pulses core_dly cycles after Run (0 = never).
    initial begin
        bus.Done = 1'b0;
        forever begin
            @(negedge Clock);
            core_r = bus.Run;
            @(posedge Clock);
            #1;
            if (!Resetn) pend = 0;
            else if (core_r && core_dly > 0) pend = core_dly;
            bus.Done = pend == 1;
            if (pend > 0) pend--;
        end
    end

    initial begin
        iss_t e;
        forever begin
            @(negedge Clock);
            cyc++;
            if (bus.Busy) busy_cnt++;
            if (imm_pend) begin
                chk("mvi_imm", int'(bus.DIN), imm_val);
                imm_log.push_back(int'(bus.DIN));
                imm_pend = 0;
            end
            if (bus.Run) begin
                chk("run_gap", int'(cyc - last_run >= 2), 1);
                chk("run_busy", int'(bus.Busy), 1);
                chk("run_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("run_pc", int'(bus.PC), e.addr);
                    chk("run_din", int'(bus.DIN), e.word);
                    imm_pend = e.mvi;
                    imm_val  = e.imm;
                end
                run_din.push_back(int'(bus.DIN));
                last_run = cyc;
            end
            if (bus.Err && !err_prev) chk("err_gap", cyc - last_run, TO + 1);
            err_prev = bus.Err;
        end
    end

    task automatic load(input int a, input int d);
        bus.LdEn   = 1'b1;
        bus.LdAddr = 5'(a);
        bus.LdData = 9'(d);
        pm[a]      = 9'(d);
        @(posedge Clock);
        #1 bus.LdEn = 1'b0;
    endtask

    // mode: 0 plain, 1 LdEn with Start, 2 LdEn while busy, 3 reset during WAIT
    task automatic run(input int last, input int dly, input int mode, input int la, input int ld);
        int n = 0;
        walk(last, dly);
        core_dly = dly;
        busy_cnt = 0;
        run_din.delete();
        imm_log.delete();
        bus.LastAddr = 5'(last);
        bus.Start    = 1'b1;
        if (mode == 1) begin
            bus.LdEn   = 1'b1;
            bus.LdAddr = 5'(la);
            bus.LdData = 9'(ld);
        end
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        bus.LdEn  = 1'b0;
        @(negedge Clock);
        chk("start_run", int'(bus.Run), 1);
        chk("start_err", int'(bus.Err), 0);
        chk("start_halted", int'(bus.Halted), 0);
        if (mode == 2) begin
            @(posedge Clock);
            #1;
            bus.LdEn   = 1'b1;
            bus.LdAddr = 5'(la);
            bus.LdData = 9'(ld);
            chk("ld_busy", int'(bus.Busy), 1);
            @(posedge Clock);
            #1 bus.LdEn = 1'b0;
        end
        if (mode == 3) begin
            @(posedge Clock);
            @(posedge Clock);
            #2;
            chk("pre_rst_busy", int'(bus.Busy), 1);
            chk("pre_rst_pc", int'(bus.PC), 1);
            Resetn = 1'b0;
            #1;
            chk("rst_run", int'(bus.Run), 0);
            chk("rst_pc", int'(bus.PC), 0);
            chk("rst_busy", int'(bus.Busy), 0);
            chk("rst_din", int'(bus.DIN), 0);
            @(posedge Clock);
            #1;
            @(posedge Clock);
            #1 Resetn = 1'b1;
            return;
        end
        while (!(bus.Halted || bus.Err) && n < 600) begin
            @(negedge Clock);
            n++;
        end
        chk("run_bounded", int'(n < 600), 1);
        chk("end_halted", int'(bus.Halted), exp_halt);
        chk("end_err", int'(bus.Err), 1 - exp_halt);
        chk("end_pc", int'(bus.PC), exp_pc);
        chk("end_issued_all", exp_q.size(), 0);
        chk("end_busy_cycles", busy_cnt, exp_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) pm[i] = '0;
        bus.Start = 0; bus.LastAddr = 0; bus.LdEn = 0; bus.LdAddr = 0; bus.LdData = 0;
        sbus.Start = 0; sbus.LastAddr = 0; sbus.LdEn = 0; sbus.LdAddr = 0; sbus.LdData = 0;
        sbus.Done = 1'b1;
        #1 Resetn = 1'b0;
        #1;
        chk("reset_run", int'(bus.Run), 0);
        chk("reset_din", int'(bus.DIN), 0);
        chk("reset_pc", int'(bus.PC), 0);
        chk("reset_busy", int'(bus.Busy), 0);
        chk("reset_halted", int'(bus.Halted), 0);
        chk("reset_err", int'(bus.Err), 0);
        @(posedge Clock);
        #1 Resetn = 1'b1;

        load(0, 'h040); load(1, 'h005); load(2, 'h008);
        run(2, 1, 0, 0, 0);
        chk("t1_model_pc", exp_pc, 3);
        chk("t1_runs", run_din.size(), 2);
        if (run_din.size() == 2) begin
            chk("t1_din0", run_din[0], 'h040);
            chk("t1_din1", run_din[1], 'h008);
        end
        chk("t1_imm_seen", imm_log.size(), 1);
        if (imm_log.size() == 1) chk("t1_imm", imm_log[0], 'h005);
        chk("t1_pc", int'(bus.PC), 3);

        load(0, 'h081);
        run(0, 3, 0, 0, 0);
        chk("t2_busy", busy_cnt, 4);
        chk("t2_runs", run_din.size(), 1);
        chk("t2_pc", int'(bus.PC), 1);
        chk("t2_err", int'(bus.Err), 0);

        run(0, 0, 0, 0, 0);
        chk("t3_err", int'(bus.Err), 1);
        chk("t3_pc", int'(bus.PC), 1);
        chk("t3_busy", busy_cnt, 16);
        run(0, 1, 0, 0, 0);
        chk("t3_recover_halted", int'(bus.Halted), 1);

        run(0, 15, 0, 0, 0);
        chk("done_at_limit_halted", int'(bus.Halted), 1);
        run(0, 16, 0, 0, 0);
        chk("done_late_err", int'(bus.Err), 1);

        load(0, 'h040);
        run(2, 10, 3, 0, 0);
        run(2, 1, 0, 0, 0);
        chk("t4_replay_runs", run_din.size(), 2);

        run(2, 4, 2, 0, 'h1FF);
        run(2, 1, 0, 0, 0);
        if (run_din.size() > 0) chk("t5_busy_write_dropped", run_din[0], 'h040);
        run(2, 1, 1, 2, 'h0C0);
        run(2, 1, 0, 0, 0);
        chk("t5_start_write_runs", run_din.size(), 2);
        if (run_din.size() == 2) chk("t5_start_write_dropped", run_din[1], 'h008);

        for (int i = 0; i < 4; i++) begin
            sbus.LdEn   = 1'b1;
            sbus.LdAddr = 2'(i);
            sbus.LdData = 9'(i * 8);
            @(posedge Clock);
            #1;
        end
        sbus.LdEn     = 1'b0;
        sbus.LastAddr = 2'd3;
        sbus.Start    = 1'b1;
        @(posedge Clock);
        #1 sbus.Start = 1'b0;
        n = 0;
        while (!sbus.Halted && n < 40) begin
            @(negedge Clock);
            if (sbus.Run) pcs.push_back(int'(sbus.PC));
            n++;
        end
        chk("t6_bounded", int'(n < 40), 1);
        chk("t6_runs", pcs.size(), 4);
        if (pcs.size() == 4) for (int k = 0; k < 4; k++) chk("t6_pc_seq", pcs[k], k);
        chk("t6_halted", int'(sbus.Halted), 1);
        chk("t6_pc_wrap", int'(sbus.PC), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
